// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Boot stage that sits in front of the single-cycle RV32 core. It receives a
// byte-wide frame over a valid/ready link and builds little-endian 32-bit
// instruction words from it. Each finished word is written to instruction
// memory, starting at word address 0. The core is held in reset until the
// whole image has arrived and its XOR checksum matches.
//
// Frame layout:
//   count_lo, count_hi, 4*N payload bytes (each word LSB first), csum
//   csum is the XOR of every earlier byte of the frame, count bytes included.
//
// Parameters:
//   ADDR_W       instruction-memory word-address width (2^ADDR_W words)
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous active-low reset
//   rx_data      incoming byte
//   rx_valid     rx_data valid this cycle
//   rx_ready     loader can accept a byte (transfer = rx_valid & rx_ready)
//   start        one-cycle reload request, honoured only in DONE or ERR
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_waddr   word address of the write
//   imem_wdata   instruction word being written
//   cpu_reset_n  core hold, 1 only once a verified image is loaded
//   done         image loaded and verified
//   error        load failed (oversize image or bad checksum)

module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_n,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Memory capacity in words, kept one bit wider than any 32-bit count so
  // the comparison below stays meaningful for every legal ADDR_W.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [7:0]        xor_acc;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [23:0]       asm_reg;

  logic              accept;
  logic              reload;
  logic [15:0]       count_full;
  logic              oversize;
  logic              word_done;
  logic              last_word;

  assign accept     = rx_valid & rx_ready;
  assign reload     = start & ((state == DONE) | (state == ERR));

  // The full count is only complete in the cycle that count_hi arrives, so
  // the branch uses the incoming byte directly rather than the latched copy.
  assign count_full = {rx_data, count[7:0]};
  assign oversize   = {17'd0, count_full} > CAPACITY;

  assign word_done  = accept & (state == DATA) & (byte_cnt == 2'd3);

  // The word counter is one bit wider than the address, so a count equal to
  // the full memory size still terminates cleanly on its last word.
  assign last_word  = (({{(31 - ADDR_W){1'b0}}, word_cnt}) + 32'd1) == {16'd0, count};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CNT_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: walk through the frame fields, then park in DONE or ERR
  // until a reload request arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      CNT_LO: begin
        if (accept) state_nxt = CNT_HI;
      end
      CNT_HI: begin
        if (accept) begin
          if (oversize) begin
            state_nxt = ERR;
          end else if (count_full == 16'd0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (word_done && last_word) state_nxt = CSUM;
      end
      CSUM: begin
        if (accept) state_nxt = (rx_data == xor_acc) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (start) state_nxt = CNT_LO;
      end
      default: state_nxt = CNT_LO;
    endcase
  end

  // Output decode: status and handshake depend on the current state only.
  always_comb begin
    rx_ready    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    cpu_reset_n = 1'b0;
    case (state)
      CNT_LO, CNT_HI, DATA, CSUM: rx_ready = 1'b1;
      DONE: begin
        done        = 1'b1;
        cpu_reset_n = 1'b1;
      end
      ERR:     error = 1'b1;
      default: rx_ready = 1'b0;
    endcase
  end

  // Datapath: count capture, running checksum, word assembly and the
  // registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      xor_acc    <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      asm_reg    <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        count    <= '0;
        xor_acc  <= '0;
        byte_cnt <= '0;
        word_cnt <= '0;
      end else if (accept) begin
        case (state)
          CNT_LO: begin
            count[7:0] <= rx_data;
            xor_acc    <= xor_acc ^ rx_data;
          end
          CNT_HI: begin
            count[15:8] <= rx_data;
            xor_acc     <= xor_acc ^ rx_data;
          end
          DATA: begin
            xor_acc  <= xor_acc ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_reg[7:0]   <= rx_data;
              2'd1: asm_reg[15:8]  <= rx_data;
              2'd2: asm_reg[23:16] <= rx_data;
              default: begin
                // The top byte goes straight to the write port so the strobe
                // lands on the very next cycle.
                imem_we    <= 1'b1;
                imem_wdata <= {rx_data, asm_reg};
                imem_waddr <= word_cnt[ADDR_W-1:0];
                word_cnt   <= word_cnt + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//
// Bench for imem_boot_loader. A frame-level reference model keeps the bytes
// accepted in the current frame and derives every expected output from them;
// a compare process checks the DUT against it on every falling edge. Directed
// scenarios add literal expectations on top.

module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_n;
  logic              done;
  logic              error;

  int total = 0;
  int bad   = 0;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .done       (done),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: accepted bytes of the current frame plus the
  // expected write port contents.
  logic [7:0]        frame_q[$];
  logic              exp_we   = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0]       exp_data = '0;
  logic [39:0]       wr_log[$];
  logic [31:0]       word_buf[0:CAP-1];

  // 0 = still loading, 1 = verified, 2 = failed
  function automatic int frame_status();
    int         n;
    logic [7:0] x;
    if (frame_q.size() < 2) return 0;
    n = int'({frame_q[1], frame_q[0]});
    if (n > CAP) return 2;
    if (frame_q.size() < 3 + 4 * n) return 0;
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame_q[i];
    return (frame_q[2 + 4 * n] == x) ? 1 : 2;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, using only the bench's own inputs.
  int m_st;
  int m_sz;
  int m_n;
  int m_w;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q.delete();
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      m_st   = frame_status();
      exp_we = 1'b0;
      if (m_st != 0) begin
        if (start) frame_q.delete();
      end else if (rx_valid) begin
        frame_q.push_back(rx_data);
        m_sz = frame_q.size();
        if (m_sz >= 6) begin
          m_n = int'({frame_q[1], frame_q[0]});
          if (m_n <= CAP && m_sz <= 2 + 4 * m_n && ((m_sz - 2) % 4) == 0) begin
            m_w      = (m_sz - 2) / 4 - 1;
            exp_we   = 1'b1;
            exp_addr = m_w[ADDR_W-1:0];
            exp_data = {frame_q[m_sz-1], frame_q[m_sz-2], frame_q[m_sz-3], frame_q[m_sz-4]};
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus a log of DUT writes.
  int c_st;
  always @(negedge clk) begin
    c_st = frame_status();
    check_output("rx_ready",    32'(rx_ready),    32'(c_st == 0));
    check_output("done",        32'(done),        32'(c_st == 1));
    check_output("error",       32'(error),       32'(c_st == 2));
    check_output("cpu_reset_n", 32'(cpu_reset_n), 32'(c_st == 1));
    check_output("imem_we",     32'(imem_we),     32'(exp_we));
    check_output("imem_waddr",  32'(imem_waddr),  32'(exp_addr));
    check_output("imem_wdata",  imem_wdata,       exp_data);
    if (imem_we) wr_log.push_back({imem_waddr, imem_wdata});
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    repeat ($urandom_range(max_gap, 0)) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends a frame of n words from word_buf; the checksum is XORed with flip
  // so a nonzero flip produces a bad checksum. Oversize counts are followed
  // by junk bytes that the loader must ignore.
  task automatic apply_stimulus(input int n, input logic [7:0] flip, input int max_gap);
    logic [7:0] x;
    logic [7:0] b;
    logic [31:0] w;
    x = 8'h00;
    b = n[7:0];
    send_byte(b, max_gap);
    x = x ^ b;
    b = n[15:8];
    send_byte(b, max_gap);
    x = x ^ b;
    if (n > CAP) begin
      repeat (3) send_byte(8'($urandom), max_gap);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = word_buf[i];
        for (int k = 0; k < 4; k++) begin
          b = w[8*k +: 8];
          send_byte(b, max_gap);
          x = x ^ b;
        end
      end
      send_byte(x ^ flip, max_gap);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  int base;
  int n_rand;
  logic [7:0] flip_rand;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check_output("rst_we",    32'(imem_we),     32'd0);
    check_output("rst_addr",  32'(imem_waddr),  32'd0);
    check_output("rst_data",  imem_wdata,       32'd0);
    check_output("rst_cpu",   32'(cpu_reset_n), 32'd0);
    check_output("rst_done",  32'(done),        32'd0);
    check_output("rst_error", 32'(error),       32'd0);
    #2 reset = 1'b1;

    // Single word: 01 00 93 00 A0 00 32
    base = wr_log.size();
    word_buf[0] = 32'h00A00093;
    apply_stimulus(1, 8'h00, 0);
    idle(2);
    check_output("single_writes", 32'(wr_log.size() - base), 32'd1);
    check_output("single_addr",   32'(wr_log[base][39:32]),  32'd0);
    check_output("single_data",   wr_log[base][31:0],        32'h00A00093);
    check_output("single_done",   32'(done),                 32'd1);
    check_output("single_cpu",    32'(cpu_reset_n),          32'd1);
    check_output("single_err",    32'(error),                32'd0);
    check_output("model_single",  32'(frame_status()),       32'd1);

    // Bad checksum (csum byte 0x33)
    pulse_start();
    base = wr_log.size();
    apply_stimulus(1, 8'h01, 0);
    idle(2);
    check_output("badcs_writes", 32'(wr_log.size() - base), 32'd1);
    check_output("badcs_addr",   32'(wr_log[base][39:32]),  32'd0);
    check_output("badcs_err",    32'(error),                32'd1);
    check_output("badcs_done",   32'(done),                 32'd0);
    check_output("badcs_cpu",    32'(cpu_reset_n),          32'd0);

    // Empty image: 00 00 00
    pulse_start();
    base = wr_log.size();
    apply_stimulus(0, 8'h00, 0);
    check_output("empty_done",   32'(done),                 32'd1);
    check_output("empty_writes", 32'(wr_log.size() - base), 32'd0);

    // Oversize: 01 01 (N=257)
    pulse_start();
    base = wr_log.size();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    idle(1);
    check_output("over_err",    32'(error),                32'd1);
    check_output("over_ready",  32'(rx_ready),             32'd0);
    check_output("model_over",  32'(frame_status()),       32'd2);
    apply_stimulus(CAP + 1, 8'h00, 0);
    check_output("over_writes", 32'(wr_log.size() - base), 32'd0);

    // Full image with gaps: word i = i
    pulse_start();
    base = wr_log.size();
    for (int i = 0; i < CAP; i++) word_buf[i] = 32'(i);
    apply_stimulus(CAP, 8'h00, 2);
    idle(1);
    check_output("full_writes", 32'(wr_log.size() - base), 32'(CAP));
    for (int i = 0; i < CAP && base + i < wr_log.size(); i++) begin
      check_output("full_addr", 32'(wr_log[base+i][39:32]), 32'(i));
      check_output("full_data", wr_log[base+i][31:0],       32'(i));
    end
    check_output("full_done", 32'(done), 32'd1);

    // Reload with start coincident with a valid byte, then a 2-word frame
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    check_output("reload_cpu",  32'(cpu_reset_n), 32'd0);
    check_output("reload_done", 32'(done),        32'd0);
    base = wr_log.size();
    word_buf[0] = 32'hDEADBEEF;
    word_buf[1] = 32'h12345678;
    apply_stimulus(2, 8'h00, 1);
    idle(1);
    check_output("reload_writes", 32'(wr_log.size() - base), 32'd2);
    check_output("reload_a0",     32'(wr_log[base][39:32]),  32'd0);
    check_output("reload_d0",     wr_log[base][31:0],        32'hDEADBEEF);
    check_output("reload_a1",     32'(wr_log[base+1][39:32]), 32'd1);
    check_output("reload_d1",     wr_log[base+1][31:0],      32'h12345678);
    check_output("reload_done2",  32'(done),                 32'd1);

    // Reset after word 0 of a new frame
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    idle(2);
    #2 reset = 1'b0;
    @(negedge clk);
    check_output("mid_we",    32'(imem_we),     32'd0);
    check_output("mid_addr",  32'(imem_waddr),  32'd0);
    check_output("mid_data",  imem_wdata,       32'd0);
    check_output("mid_cpu",   32'(cpu_reset_n), 32'd0);
    check_output("mid_done",  32'(done),        32'd0);
    check_output("mid_error", 32'(error),       32'd0);
    #2 reset = 1'b1;
    base = wr_log.size();
    word_buf[0] = 32'(($urandom));
    apply_stimulus(1, 8'h00, 1);
    check_output("fresh_writes", 32'(wr_log.size() - base), 32'd1);
    check_output("fresh_data",   wr_log[base][31:0],        word_buf[0]);
    check_output("fresh_done",   32'(done),                 32'd1);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      pulse_start();
      base   = wr_log.size();
      n_rand = ($urandom_range(7, 0) == 0) ? CAP + 4 : int'($urandom_range(6, 0));
      for (int i = 0; i < 6; i++) word_buf[i] = 32'($urandom);
      flip_rand = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      apply_stimulus(n_rand, flip_rand, 3);
      idle(3);
      check_output("rand_writes", 32'(wr_log.size() - base), 32'((n_rand <= CAP) ? n_rand : 0));
      check_output("rand_done",   32'(done), 32'((n_rand <= CAP) && (flip_rand == 8'h00)));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
